// File: rtl/ext_irq_ctrl.sv
// External interrupt requester: edge-collects device lines, grants the lowest pending source
// to the CPU over a four-phase ExtIRQ/ExtIAck handshake. Define IRQ_MASK_EN for a writable mask.
module ext_irq_ctrl #(
    parameter int N_SRC = 4,
    parameter int ID_W  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] dev_irq,
    input  logic             ExtIAck,
`ifdef IRQ_MASK_EN
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
`endif
    output logic             ExtIRQ,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_SRC-1:0] irq_pending
);

    // state   | meaning
    // IDLE    | no grant outstanding; pick lowest eligible pending source
    // REQ     | ExtIRQ held with stable irq_id until ExtIAck
    // RELEASE | source retired; wait for ExtIAck to drop
    typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

    state_t           state;
    logic [N_SRC-1:0] dev_q;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] clr;

    function automatic logic [ID_W-1:0] lowest_idx(input logic [N_SRC-1:0] v);
        lowest_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = ID_W'(i);
        end
    endfunction

`ifdef IRQ_MASK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask <= '1;
        end else if (mask_we) begin
            mask <= mask_wdata;
        end
    end
`else
    assign mask = '1;
`endif

    assign rise     = dev_irq & ~dev_q;
    assign eligible = pending & mask;

    always_comb begin
        clr = '0;
        if (state == REQ && ExtIAck) begin
            for (int i = 0; i < N_SRC; i++) begin
                clr[i] = (irq_id == ID_W'(i));
            end
        end
    end

    // rise is OR-ed after the clear so a re-request on the retire edge survives
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dev_q   <= '0;
            pending <= '0;
        end else begin
            dev_q   <= dev_irq;
            pending <= (pending & ~clr) | rise;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ExtIRQ <= 1'b0;
            irq_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (eligible != '0) begin
                        irq_id <= lowest_idx(eligible);
                        ExtIRQ <= 1'b1;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (ExtIAck) begin
                        ExtIRQ <= 1'b0;
                        state  <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!ExtIAck) state <= IDLE;
                end
                default: begin
                    ExtIRQ <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign irq_pending = pending;

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Self-checking bench for ext_irq_ctrl: directed handshake scenarios plus random traffic
// against a transaction-level reference model. Build with +define+IRQ_MASK_EN for mask tests.
module tb_ext_irq_ctrl;
    localparam int N = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] dev_irq;
    logic         ExtIAck;
    logic         ExtIRQ;
    logic [W-1:0] irq_id;
    logic [N-1:0] irq_pending;
`ifdef IRQ_MASK_EN
    logic         mask_we;
    logic [N-1:0] mask_wdata;
`endif

    ext_irq_ctrl #(.N_SRC(N), .ID_W(W)) dut (
        .clk(clk),
        .reset(reset),
        .dev_irq(dev_irq),
        .ExtIAck(ExtIAck),
`ifdef IRQ_MASK_EN
        .mask_we(mask_we),
        .mask_wdata(mask_wdata),
`endif
        .ExtIRQ(ExtIRQ),
        .irq_id(irq_id),
        .irq_pending(irq_pending)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Reference model: a grant is either outstanding, waiting for ack release, or absent.
    logic [N-1:0] m_pend, m_prev, m_mask;
    bit           m_grant, m_wait_rel;
    int           m_id;

    task automatic model_reset();
        m_pend = '0; m_prev = '0; m_mask = '1;
        m_grant = 0; m_wait_rel = 0; m_id = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] newreq, retire, avail, lowbit;
        if (reset) begin
            model_reset();
            return;
        end
        newreq = dev_irq & ~m_prev;
        retire = '0;
        if (m_grant) begin
            if (ExtIAck) begin
                retire[m_id] = 1'b1;
                m_grant = 0;
                m_wait_rel = 1;
            end
        end else if (m_wait_rel) begin
            if (!ExtIAck) m_wait_rel = 0;
        end else begin
            avail = m_pend & m_mask;
            if (avail != 0) begin
                lowbit  = avail & (~avail + 1'b1);
                m_id    = $clog2(lowbit);
                m_grant = 1;
            end
        end
        m_pend = (m_pend & ~retire) | newreq;
        m_prev = dev_irq;
`ifdef IRQ_MASK_EN
        if (mask_we) m_mask = mask_wdata;
`endif
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk({tag, ".irq"}, int'(ExtIRQ), int'(m_grant));
        chk({tag, ".id"}, int'(irq_id), m_id);
        chk({tag, ".pend"}, int'(irq_pending), int'(m_pend));
    endtask

    int grants;
    bit prev_irq;

    initial begin
        reset = 1'b1; dev_irq = '0; ExtIAck = 1'b0;
`ifdef IRQ_MASK_EN
        mask_we = 1'b0; mask_wdata = '0;
`endif
        model_reset();
        cyc("reset");
        chk("reset_irq", int'(ExtIRQ), 0);
        chk("reset_pend", int'(irq_pending), 0);
        reset = 1'b0;
        cyc("idle");

        // single source
        dev_irq = 4'b0100; cyc("single_e0");
        dev_irq = 4'b0000; cyc("single_e1");
        chk("single_req", int'(ExtIRQ), 1);
        chk("single_id", int'(irq_id), 2);
        ExtIAck = 1'b1; cyc("single_ack");
        chk("single_drop", int'(ExtIRQ), 0);
        chk("single_clear", int'(irq_pending), 0);
        ExtIAck = 1'b0; cyc("single_rel");

        // priority
        dev_irq = 4'b1010; cyc("prio_e0");
        dev_irq = 4'b0000; cyc("prio_e1");
        chk("prio_first", int'(irq_id), 1);
        chk("prio_pend0", int'(irq_pending), 'b1010);
        ExtIAck = 1'b1; cyc("prio_ack1");
        chk("prio_pend1", int'(irq_pending), 'b1000);
        ExtIAck = 1'b0; cyc("prio_rel");
        cyc("prio_idle");
        chk("prio_second", int'(irq_id), 3);
        ExtIAck = 1'b1; cyc("prio_ack2");
        chk("prio_pend2", int'(irq_pending), 0);
        ExtIAck = 1'b0; cyc("prio_rel2");

        // re-request on the retire edge
        dev_irq = 4'b0001; cyc("rereq_e0");
        dev_irq = 4'b0000; cyc("rereq_e1");
        dev_irq = 4'b0001; ExtIAck = 1'b1; cyc("rereq_ack");
        chk("rereq_keep", int'(irq_pending[0]), 1);
        dev_irq = 4'b0000; ExtIAck = 1'b0; cyc("rereq_rel");
        cyc("rereq_grant");
        chk("rereq_again", int'(ExtIRQ), 1);
        chk("rereq_id", int'(irq_id), 0);

        // level ack held for 5 cycles while a new request arrives
        ExtIAck = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dev_irq = (i == 1) ? 4'b0100 : 4'b0000;
            cyc("level_ack");
            chk("level_low", int'(ExtIRQ), 0);
        end
        ExtIAck = 1'b0; cyc("level_rel");
        cyc("level_grant");
        chk("level_id", int'(irq_id), 2);

        // asynchronous reset mid-REQ
        reset = 1'b1;
        #1;
        chk("async_irq", int'(ExtIRQ), 0);
        chk("async_pend", int'(irq_pending), 0);
        cyc("async_hold");
        reset = 1'b0; cyc("async_rel");

        // held line produces exactly one grant
        grants = 0; prev_irq = 1'b0;
        dev_irq = 4'b0010;
        for (int i = 0; i < 20; i++) begin
            ExtIAck = m_grant;
            cyc("held");
            if (ExtIRQ && !prev_irq) grants++;
            prev_irq = ExtIRQ;
        end
        chk("held_grants", grants, 1);
        dev_irq = '0; ExtIAck = 1'b0;
        cyc("held_end"); cyc("held_end");

`ifdef IRQ_MASK_EN
        mask_we = 1'b1; mask_wdata = 4'b1110; cyc("mask_wr");
        mask_we = 1'b0; dev_irq = 4'b0001; cyc("mask_e0");
        dev_irq = 4'b0000; cyc("mask_e1"); cyc("mask_e2");
        chk("mask_block", int'(ExtIRQ), 0);
        chk("mask_pend", int'(irq_pending), 'b0001);
        mask_we = 1'b1; mask_wdata = 4'b1111; cyc("unmask_wr");
        mask_we = 1'b0; cyc("unmask_e1");
        chk("unmask_req", int'(ExtIRQ), 1);
        chk("unmask_id", int'(irq_id), 0);
        ExtIAck = 1'b1; cyc("unmask_ack");
        ExtIAck = 1'b0; cyc("unmask_rel");
`endif

        // random traffic
        for (int i = 0; i < 400; i++) begin
            dev_irq = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
            if (m_grant)         ExtIAck = ($urandom_range(0, 2) == 0);
            else if (m_wait_rel) ExtIAck = ($urandom_range(0, 1) == 0);
            else                 ExtIAck = ($urandom_range(0, 3) == 0);
`ifdef IRQ_MASK_EN
            mask_we    = ($urandom_range(0, 7) == 0);
            mask_wdata = N'($urandom_range(0, 15));
`endif
            cyc("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end
endmodule
